// File: rtl/m_pool_1.sv
// Layer-1 2x2 stride-2 max pool over the conv1 raster stream; one half-row line buffer, never stalls.
// Optional output ReLU (max-then-clamp) is enabled by defining POOL_1_RELU_EN.
module m_pool_1 #(
    parameter int map_width  = 88,
    parameter int map_height = 88,
    parameter int num_out    = (map_width / 2) * (map_height / 2)
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic signed [15:0] map_in,
    input  logic               save_in,
    output logic signed [15:0] map_out,
    output logic               save,
    output logic               ready
);

    localparam int CW   = $clog2(map_width);
    localparam int RW   = $clog2(map_height);
    localparam int OW   = $clog2(num_out + 1);
    localparam int HALF = map_width / 2;
    localparam int LW   = $clog2(HALF);

    logic [CW-1:0]      col_cnt;
    logic [RW-1:0]      row_cnt;
    logic [OW-1:0]      out_cnt;
    logic signed [15:0] pair_reg;
    logic signed [15:0] line_buf [HALF];

    logic               accept;
    logic [LW-1:0]      lb_idx;
    logic signed [15:0] hmax;
    logic signed [15:0] line_rd;
    logic signed [15:0] vmax;
    logic signed [15:0] pooled;
    logic               col_last;
    logic               row_last;

    assign accept   = save_in & ready;
    assign lb_idx   = LW'(col_cnt >> 1);
    assign col_last = (col_cnt == CW'(map_width - 1));
    assign row_last = (row_cnt == RW'(map_height - 1));

    // Horizontal max of the column pair, then vertical max against the buffered even row.
    assign hmax    = (map_in > pair_reg) ? map_in : pair_reg;
    assign line_rd = line_buf[lb_idx];
    assign vmax    = (line_rd > hmax) ? line_rd : hmax;

`ifdef POOL_1_RELU_EN
    assign pooled = vmax[15] ? 16'sd0 : vmax;
`else
    assign pooled = vmax;
`endif

    // Line buffer needs no reset: each entry is written on an even row before the odd row reads it.
    always_ff @(posedge clk_in) begin
        if (rst_n && accept && col_cnt[0] && !row_cnt[0]) begin
            line_buf[lb_idx] <= hmax;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            col_cnt  <= '0;
            row_cnt  <= '0;
            out_cnt  <= '0;
            pair_reg <= '0;
            map_out  <= '0;
            save     <= 1'b0;
            ready    <= 1'b1;
        end else begin
            save <= 1'b0;
            if (accept) begin
                if (!col_cnt[0]) begin
                    pair_reg <= map_in;
                end else if (row_cnt[0]) begin
                    map_out <= pooled;
                    save    <= 1'b1;
                    out_cnt <= out_cnt + 1'b1;
                end
                if (col_last) begin
                    col_cnt <= '0;
                    row_cnt <= row_last ? '0 : row_cnt + 1'b1;
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end
            end
            // Drops one cycle after the final pulse, once out_cnt has reached the frame total.
            if (out_cnt == OW'(num_out)) begin
                ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_m_pool_1.sv
// Scoreboard bench for m_pool_1: directed frames push expected pooled values, a negedge monitor checks them.
module tb_m_pool_1;

    logic               clk_in = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] map_in = '0;
    logic               save_in = 1'b0;
    logic signed [15:0] map_out;
    logic               save;
    logic               ready;

    m_pool_1 dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .map_in (map_in),
        .save_in(save_in),
        .map_out(map_out),
        .save   (save),
        .ready  (ready)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    logic [15:0] exp_q[$];
    int          exp_cyc_q[$];
    int          total = 0;
    int          bad = 0;
    int          out_log[1936];
    int          log_idx = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // kind 0: ramp, kind 1: one 32767 per window at rotating position, kind 2: all -5
    function automatic logic signed [15:0] pixel(input int kind, input int r, input int c);
        int p;
        case (kind)
            0: return 16'(r * 88 + c);
            1: begin
                p = ((r / 2) * 44 + (c / 2)) % 4;
                return (((r % 2) * 2 + (c % 2)) == p) ? 16'sh7fff : 16'sh8000;
            end
            default: return -16'sd5;
        endcase
    endfunction

    function automatic logic signed [15:0] smax(input logic signed [15:0] a, input logic signed [15:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic signed [15:0] out_act(input logic signed [15:0] v);
`ifdef POOL_1_RELU_EN
        return (v < 0) ? 16'sd0 : v;
`else
        return v;
`endif
    endfunction

    task automatic drive(input logic signed [15:0] v, input logic vld);
        @(posedge clk_in);
        #1;
        map_in  = v;
        save_in = vld;
    endtask

    task automatic send_frame(input int kind, input int gap, input int limit);
        int r;
        int c;
        logic signed [15:0] e;
        for (int i = 0; i < limit; i++) begin
            r = i / 88;
            c = i % 88;
            for (int g = 0; g < gap; g++) drive(16'sd0, 1'b0);
            drive(pixel(kind, r, c), 1'b1);
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                e = smax(smax(pixel(kind, r - 1, c - 1), pixel(kind, r - 1, c)),
                         smax(pixel(kind, r, c - 1), pixel(kind, r, c)));
                exp_q.push_back(out_act(e));
                exp_cyc_q.push_back(cyc + 1);
            end
        end
        drive(16'sd0, 1'b0);
    endtask

    // A sample is offered during the reset cycle; reset must win and drop it.
    task automatic do_reset();
        @(posedge clk_in);
        #1;
        rst_n   = 1'b0;
        save_in = 1'b1;
        map_in  = 16'sh1234;
        @(posedge clk_in);
        #1;
        rst_n   = 1'b1;
        save_in = 1'b0;
        @(negedge clk_in);
        check("ready_after_reset", int'(ready), 1);
        check("save_after_reset", int'(save), 0);
        log_idx = 0;
    endtask

    task automatic check_ramp_log(input string tag);
        check({tag, "_count"}, log_idx, 1936);
        check({tag, "_first"}, out_log[0], 89);
        check({tag, "_44th"}, out_log[43], 175);
        check({tag, "_last"}, out_log[1935], 7743);
    endtask

    always @(negedge clk_in) begin
        if (save) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_save: got pulse with map_out=%0d, want no pulse (t=%0t)", map_out, $time);
            end else begin
                check("pool_value", int'(map_out), int'($signed(exp_q.pop_front())));
                check("save_latency", cyc, exp_cyc_q.pop_front());
                if (log_idx < 1936) out_log[log_idx] = int'(map_out);
                log_idx++;
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk_in);
        #1;
        rst_n = 1'b1;
        @(negedge clk_in);
        check("reset_map_out", int'(map_out), 0);
        check("reset_save", int'(save), 0);
        check("reset_ready", int'(ready), 1);

        // Continuous ramp frame
        send_frame(0, 0, 7744);
        @(negedge clk_in);
        check("ready_during_last_save", int'(ready), 1);
        @(negedge clk_in);
        check("ready_after_frame", int'(ready), 0);
        check_ramp_log("ramp");

        // Samples after completion are ignored
        for (int i = 0; i < 500; i++) begin
            drive(16'(i * 3 + 1), 1'b1);
            @(negedge clk_in);
            check("ready_held_low", int'(ready), 0);
        end
        drive(16'sd0, 1'b0);
        @(negedge clk_in);
        check("map_out_held", int'(map_out), 7743);

        // Max found at every window position
        do_reset();
        send_frame(1, 0, 7744);
        repeat (2) @(negedge clk_in);
        check("window_count", log_idx, 1936);
        check("window_ready_low", int'(ready), 0);

        // All-negative frame
        do_reset();
        send_frame(2, 0, 7744);
        repeat (2) @(negedge clk_in);
        check("neg_count", log_idx, 1936);

        // Ramp with save_in every third cycle
        do_reset();
        send_frame(0, 2, 7744);
        repeat (2) @(negedge clk_in);
        check_ramp_log("gapped");
        check("gapped_ready_low", int'(ready), 0);

        // Partial frame, reset mid-frame, then a clean frame
        do_reset();
        send_frame(0, 0, 1000);
        repeat (2) @(negedge clk_in);
        check("partial_count", log_idx, 236);
        do_reset();
        send_frame(0, 0, 7744);
        repeat (2) @(negedge clk_in);
        check_ramp_log("after_reset");
        check("after_reset_ready_low", int'(ready), 0);

        repeat (4) @(negedge clk_in);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
